// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : noc_pkg
// Purpose  : Shared router definitions: direction codes, output-port FSM
//            state encoding, flit geometry defaults and small helpers used
//            by the output stage and its arbiter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package noc_pkg;

    // Flit geometry defaults
    localparam int C_MSB_SLOT = 5;
    localparam int C_DSIZE    = 1 << C_MSB_SLOT;
    localparam int C_NPORTS   = 5;

    // Direction codes; bit position in a 5-bit request vector equals the code
    localparam logic [2:0] C_DIR_N       = 3'b000;
    localparam logic [2:0] C_DIR_S       = 3'b001;
    localparam logic [2:0] C_DIR_E       = 3'b010;
    localparam logic [2:0] C_DIR_W       = 3'b011;
    localparam logic [2:0] C_DIR_L       = 3'b100;
    localparam logic [2:0] C_DIR_INVALID = 3'b111;

    // Output-port FSM state encoding
    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t C_ST_IDLE    = 2'b00;
    localparam fsm_state_t C_ST_GRANT   = 2'b01;
    localparam fsm_state_t C_ST_CAPTURE = 2'b10;
    localparam fsm_state_t C_ST_HOLD    = 2'b11;

    // Round-robin successor of a requester index (4 wraps to 0)
    function automatic logic [2:0] next_ptr(input logic [2:0] idx);
        return (idx >= 3'd4) ? 3'd0 : idx + 3'd1;
    endfunction

    // Index to one-hot over the five requesters; out-of-range gives zero
    function automatic logic [4:0] idx_to_onehot(input logic [2:0] idx);
        return (idx <= 3'd4) ? (5'b00001 << idx) : 5'b00000;
    endfunction

    // A flit may not turn back to the router it came from, except the local
    // port, which legitimately loops NI traffic back to itself.
    function automatic logic [4:0] uturn_mask(input logic [2:0] port);
        return (port == C_DIR_L) ? 5'b00000 : idx_to_onehot(port);
    endfunction

endpackage
`default_nettype wire

// File: rtl/output_port_module_if.sv
`default_nettype none
// ============================================================================
// Module   : output_port_module_if
// Purpose  : Bundles the upstream VC request/read signals and the downstream
//            empty/read handshake of one router output port.
// Ports    : req[4:0]        requests from the five input modules
//            data_in[5*D-1:0] flattened VC head flits
//            read_en[4:0]    one-hot VC read strobe
//            data_out[D-1:0] registered flit to downstream
//            out_avail       flit held for downstream
//            out_read        downstream consumes the flit
//            down_full       downstream buffer full
//            modport master = output stage, modport slave = its environment
// Revision : 1.0 - initial release
// ============================================================================
interface output_port_module_if
    import noc_pkg::*;
#(
    parameter int DSIZE = C_DSIZE
);
    logic [C_NPORTS-1:0]       req;
    logic [C_NPORTS*DSIZE-1:0] data_in;
    logic [C_NPORTS-1:0]       read_en;
    logic [DSIZE-1:0]          data_out;
    logic                      out_avail;
    logic                      out_read;
    logic                      down_full;

    modport master (
        input  req,
        input  data_in,
        input  out_read,
        input  down_full,
        output read_en,
        output data_out,
        output out_avail
    );

    modport slave (
        output req,
        output data_in,
        output out_read,
        output down_full,
        input  read_en,
        input  data_out,
        input  out_avail
    );
endinterface
`default_nettype wire

// File: rtl/rr_grant5.sv
`default_nettype none
// ============================================================================
// Module   : rr_grant5
// Purpose  : Combinational masked round-robin priority encoder over five
//            requesters. Search starts at pointer and wraps modulo 5.
// Ports    : req[4:0]     request vector (already U-turn filtered)
//            pointer[2:0] highest-priority requester index (0..4)
//            grant[4:0]   one-hot winner, zero when no request
//            idx[2:0]     winner index, zero when no request
// Revision : 1.0 - initial release
// ============================================================================
module rr_grant5
    import noc_pkg::*;
(
    input  logic [4:0] req,
    input  logic [2:0] pointer,
    output logic [4:0] grant,
    output logic [2:0] idx
);

    logic [4:0] w_below_ptr;
    logic [4:0] w_req_upper;

    function automatic logic [2:0] lowest_set(input logic [4:0] v);
        logic [2:0] r;
        if (v[0])      r = 3'd0;
        else if (v[1]) r = 3'd1;
        else if (v[2]) r = 3'd2;
        else if (v[3]) r = 3'd3;
        else           r = 3'd4;
        return r;
    endfunction

    // Requests at or above the pointer take precedence; if none exist the
    // search has wrapped and the lowest request overall wins.
    assign w_below_ptr = (5'b00001 << pointer) - 5'b00001;
    assign w_req_upper = req & ~w_below_ptr;

    assign idx   = (|w_req_upper) ? lowest_set(w_req_upper) :
                   (|req)         ? lowest_set(req)         : 3'd0;
    assign grant = (|req) ? idx_to_onehot(idx) : 5'b00000;

endmodule
`default_nettype wire

// File: rtl/output_port_module.sv
`default_nettype none
// ============================================================================
// Module   : output_port_module
// Purpose  : Router output stage for one direction. Round-robin arbitrates
//            the input modules' VC requests, pulses read_en to the winner,
//            captures its flit one cycle later and holds it for downstream
//            until consumed.
// Ports    : clk            rising-edge clock
//            reset          asynchronous active-low reset
//            bus            output_port_module_if.master (req/data_in/read_en,
//                           data_out/out_avail/out_read/down_full)
//            busy           FSM not in IDLE
//            flit_count     flits consumed downstream (saturating)
//            grant_hist     sticky OR of all grants since reset
// Option   : OUTPUT_PORT_FLIT_COUNT_EN adds flit_count and grant_hist.
// Revision : 1.0 - initial release
// ============================================================================
module output_port_module
    import noc_pkg::*;
#(
    parameter int         MSB_SLOT = C_MSB_SLOT,
    parameter int         DSIZE    = 1 << MSB_SLOT,
    parameter logic [2:0] PORT     = C_DIR_N,
    parameter int         NPORTS   = C_NPORTS
)(
    input  wire logic                 clk,
    input  wire logic                 reset,
    output_port_module_if.master      bus,
    output logic                      busy
`ifdef OUTPUT_PORT_FLIT_COUNT_EN
    ,
    output logic [31:0]               flit_count,
    output logic [NPORTS-1:0]         grant_hist
`endif
);

    localparam logic [NPORTS-1:0] C_UTURN_MASK = uturn_mask(PORT);

    fsm_state_t        r_state;
    logic [2:0]        r_ptr;
    logic [2:0]        r_winner_idx;
    logic [NPORTS-1:0] r_winner_oh;
    logic [DSIZE-1:0]  r_data_out;
    logic              r_out_avail;

    logic [NPORTS-1:0] w_req_eligible;
    logic              w_can_grant;
    logic [NPORTS-1:0] w_grant_oh;
    logic [2:0]        w_grant_idx;
    logic [NPORTS-1:0] w_read_en;
    logic              w_consume;

    assign w_req_eligible = bus.req & ~C_UTURN_MASK;
    assign w_can_grant    = (|w_req_eligible) && !bus.down_full;
    assign w_consume      = bus.out_read && r_out_avail;

    rr_grant5 u_rr_grant5 (
        .req     (w_req_eligible),
        .pointer (r_ptr),
        .grant   (w_grant_oh),
        .idx     (w_grant_idx)
    );

    // read_en is decoded from state so an asynchronous reset removes it at once
    assign w_read_en     = (r_state == C_ST_GRANT) ? r_winner_oh : '0;
    assign bus.read_en   = w_read_en;
    assign bus.data_out  = r_data_out;
    assign bus.out_avail = r_out_avail;
    assign busy          = (r_state != C_ST_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= C_ST_IDLE;
            r_ptr        <= 3'd0;
            r_winner_idx <= 3'd0;
            r_winner_oh  <= '0;
            r_data_out   <= '0;
            r_out_avail  <= 1'b0;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (w_can_grant) begin
                        r_winner_idx <= w_grant_idx;
                        r_winner_oh  <= w_grant_oh;
                        r_ptr        <= next_ptr(w_grant_idx);
                        r_state      <= C_ST_GRANT;
                    end
                end
                C_ST_GRANT: begin
                    r_state <= C_ST_CAPTURE;
                end
                C_ST_CAPTURE: begin
                    // VC head is valid the cycle after its read strobe
                    r_data_out  <= bus.data_in[(int'(r_winner_idx) << MSB_SLOT) +: DSIZE];
                    r_out_avail <= 1'b1;
                    r_state     <= C_ST_HOLD;
                end
                C_ST_HOLD: begin
                    if (w_consume) begin
                        r_out_avail <= 1'b0;
                        // Back-to-back: arbitrate again in the consume cycle
                        if (w_can_grant) begin
                            r_winner_idx <= w_grant_idx;
                            r_winner_oh  <= w_grant_oh;
                            r_ptr        <= next_ptr(w_grant_idx);
                            r_state      <= C_ST_GRANT;
                        end else begin
                            r_state <= C_ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= C_ST_IDLE;
                end
            endcase
        end
    end

`ifdef OUTPUT_PORT_FLIT_COUNT_EN
    logic [31:0]       r_flit_count;
    logic [NPORTS-1:0] r_grant_hist;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flit_count <= 32'd0;
            r_grant_hist <= '0;
        end else begin
            if (w_consume && (r_flit_count != 32'hFFFF_FFFF)) begin
                r_flit_count <= r_flit_count + 32'd1;
            end
            r_grant_hist <= r_grant_hist | w_read_en;
        end
    end

    assign flit_count = r_flit_count;
    assign grant_hist = r_grant_hist;
`endif

endmodule
`default_nettype wire

// File: tb/tb_output_port_module.sv
`default_nettype none
// ============================================================================
// Module   : tb_output_port_module
// Purpose  : Self-checking bench for output_port_module (PORT = N). Expected
//            grants come from a transaction-level round-robin model; flit
//            data is random and tracked per transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_output_port_module;

    logic clk = 1'b0;
    logic reset;
    logic busy;

    always #5 clk = ~clk;

    output_port_module_if #(.DSIZE(32)) bus ();

`ifdef OUTPUT_PORT_FLIT_COUNT_EN
    logic [31:0] flit_count;
    logic [4:0]  grant_hist;
`endif

    output_port_module #(
        .MSB_SLOT (5),
        .DSIZE    (32),
        .PORT     (3'b000),
        .NPORTS   (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master),
        .busy  (busy)
`ifdef OUTPUT_PORT_FLIT_COUNT_EN
        ,
        .flit_count (flit_count),
        .grant_hist (grant_hist)
`endif
    );

    int         n_checks   = 0;
    int         n_pass     = 0;
    int         n_fail     = 0;
    int         p          = 0;     // model round-robin pointer
    int         n_consumed = 0;     // model flit count since reset
    logic [4:0] hist       = '0;    // model grant history since reset

    function automatic logic [4:0] oh(input int i);
        return 5'(1 << i);
    endfunction

    // Winner: first requester at or after ptr, wrapping mod 5; N (this
    // port's own direction) is never eligible.
    function automatic int pick(input logic [4:0] r, input int ptr);
        logic [4:0] eligible;
        int         win;
        eligible = r & 5'b11110;
        win = -1;
        for (int k = 0; k < 5; k++) begin
            if (win < 0 && eligible[(ptr + k) % 5]) win = (ptr + k) % 5;
        end
        return win;
    endfunction

    function automatic logic [159:0] rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // From IDLE: request, check grant, capture and presentation; ends at the
    // first HOLD negedge with the flit checked.
    task automatic to_hold(input logic [4:0] r, input bit keep_req, input logic [159:0] d,
                           output logic [31:0] dw);
        int w;
        w = pick(r, p);
        bus.down_full = 1'b0;
        bus.req       = r;
        bus.data_in   = rnd();
        @(negedge clk);
        chk("grant_read_en", 32'(bus.read_en), 32'(oh(w)));
        chk("grant_busy", 32'(busy), 32'd1);
        p    = (w + 1) % 5;
        hist = hist | oh(w);
        if (!keep_req) bus.req = '0;
        bus.data_in = rnd();            // not yet valid: must not be captured
        @(negedge clk);
        chk("capture_read_en", 32'(bus.read_en), 32'd0);
        chk("capture_avail", 32'(bus.out_avail), 32'd0);
        bus.data_in = d;
        dw = d[w*32 +: 32];
        @(negedge clk);
        chk("hold_avail", 32'(bus.out_avail), 32'd1);
        chk("hold_data", bus.data_out, dw);
        bus.data_in = rnd();
    endtask

    task automatic consume();
        bus.out_read = 1'b1;
        bus.req      = '0;
        @(negedge clk);
        bus.out_read = 1'b0;
        n_consumed++;
        chk("consumed_avail", 32'(bus.out_avail), 32'd0);
        chk("consumed_busy", 32'(busy), 32'd0);
    endtask

    // Back-to-back transfers with out_read held high; req dropped before the
    // last HOLD so the port returns to IDLE.
    task automatic stream(input logic [4:0] r, input int n);
        int          w;
        logic [159:0] d;
        logic [31:0]  dw;
        bus.down_full = 1'b0;
        bus.req       = r;
        bus.out_read  = 1'b1;
        bus.data_in   = rnd();
        for (int g = 0; g < n; g++) begin
            w = pick(r, p);
            @(negedge clk);
            chk("rr_read_en", 32'(bus.read_en), 32'(oh(w)));
            p    = (w + 1) % 5;
            hist = hist | oh(w);
            bus.data_in = rnd();
            @(negedge clk);
            d  = rnd();
            bus.data_in = d;
            dw = d[w*32 +: 32];
            @(negedge clk);
            chk("rr_avail", 32'(bus.out_avail), 32'd1);
            chk("rr_data", bus.data_out, dw);
            bus.data_in = rnd();
            n_consumed++;
            if (g == n - 1) bus.req = '0;
        end
        @(negedge clk);
        chk("rr_end_avail", 32'(bus.out_avail), 32'd0);
        chk("rr_end_busy", 32'(busy), 32'd0);
        bus.out_read = 1'b0;
    endtask

    initial begin
        logic [159:0] d;
        logic [31:0]  dw;
        logic [4:0]   r;

        bus.req       = '0;
        bus.data_in   = '0;
        bus.out_read  = 1'b0;
        bus.down_full = 1'b0;
        reset         = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_read_en", 32'(bus.read_en), 32'd0);
        chk("rst_data_out", bus.data_out, 32'd0);
        chk("rst_avail", 32'(bus.out_avail), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
`ifdef OUTPUT_PORT_FLIT_COUNT_EN
        chk("rst_flit_count", flit_count, 32'd0);
        chk("rst_grant_hist", 32'(grant_hist), 32'd0);
`endif
        reset = 1'b1;
        @(negedge clk);

        // Single request from S with a known flit
        d = rnd();
        d[32 +: 32] = 32'hDEAD_BEEF;
        to_hold(5'b00010, 1'b0, d, dw);
        chk("single_data", bus.data_out, 32'hDEAD_BEEF);
        consume();

        // out_read with nothing held is ignored
        bus.out_read = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("idle_read_busy", 32'(busy), 32'd0);
            chk("idle_read_avail", 32'(bus.out_avail), 32'd0);
        end
        bus.out_read = 1'b0;

        // U-turn: N alone is never granted, N+S grants S
        bus.req = 5'b00001;
        repeat (4) begin
            @(negedge clk);
            chk("uturn_read_en", 32'(bus.read_en), 32'd0);
            chk("uturn_busy", 32'(busy), 32'd0);
        end
        to_hold(5'b00011, 1'b0, rnd(), dw);
        consume();

        // Backpressure: no grant while down_full, grant on the cycle after release
        bus.down_full = 1'b1;
        bus.req       = 5'b00100;
        repeat (10) begin
            @(negedge clk);
            chk("bp_read_en", 32'(bus.read_en), 32'd0);
        end
        to_hold(5'b00100, 1'b0, rnd(), dw);
        consume();

        // Hold: flit stable, no new grant while unread; down_full rises in HOLD
        to_hold(5'b01000, 1'b1, rnd(), dw);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) bus.down_full = 1'b1;
            @(negedge clk);
            chk("hold_stable_data", bus.data_out, dw);
            chk("hold_stable_avail", 32'(bus.out_avail), 32'd1);
            chk("hold_no_read_en", 32'(bus.read_en), 32'd0);
        end
        bus.out_read = 1'b1;
        @(negedge clk);
        bus.out_read = 1'b0;
        n_consumed++;
        chk("hold_full_avail", 32'(bus.out_avail), 32'd0);
        chk("hold_full_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("hold_full_read_en", 32'(bus.read_en), 32'd0);
        to_hold(5'b01000, 1'b0, rnd(), dw);
        consume();

        // Round-robin fairness with continuous consumption
        stream(5'b10110, 6);

        // Random traffic
        for (int it = 0; it < 16; it++) begin
            r = 5'($urandom());
            if ((r & 5'b11110) == 5'b00000) r[$urandom_range(4, 1)] = 1'b1;
            to_hold(r, 1'($urandom_range(0, 1)), rnd(), dw);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk("rand_hold_data", bus.data_out, dw);
                chk("rand_hold_read_en", 32'(bus.read_en), 32'd0);
            end
            consume();
        end

        // Asynchronous reset while read_en is asserted
        bus.down_full = 1'b0;
        bus.req       = 5'b00100;
        @(negedge clk);
        chk("pre_rst_read_en", 32'(bus.read_en), 32'(oh(pick(5'b00100, p))));
        #2 reset = 1'b0;
        #1;
        chk("async_rst_read_en", 32'(bus.read_en), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        bus.req = '0;
        @(negedge clk);
        reset = 1'b1;
        p = 0; hist = '0; n_consumed = 0;
        @(negedge clk);

        // Asynchronous reset while a flit is held (E granted, pointer moves to W)
        to_hold(5'b00100, 1'b0, rnd(), dw);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_avail", 32'(bus.out_avail), 32'd0);
        chk("async_rst_busy2", 32'(busy), 32'd0);
        chk("async_rst_data", bus.data_out, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        p = 0; hist = '0; n_consumed = 0;
`ifdef OUTPUT_PORT_FLIT_COUNT_EN
        chk("post_rst_flit_count", flit_count, 32'd0);
        chk("post_rst_grant_hist", 32'(grant_hist), 32'd0);
`endif
        @(negedge clk);

        // Pointer back at 0: E must beat L
        to_hold(5'b10100, 1'b0, rnd(), dw);
        consume();
        for (int it = 0; it < 4; it++) begin
            r = 5'($urandom());
            if ((r & 5'b11110) == 5'b00000) r[$urandom_range(4, 1)] = 1'b1;
            to_hold(r, 1'b0, rnd(), dw);
            consume();
        end
`ifdef OUTPUT_PORT_FLIT_COUNT_EN
        chk("flit_count_5", flit_count, 32'(n_consumed));
        chk("grant_hist", 32'(grant_hist), 32'(hist));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
